// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 UART receiver feeding a show-ahead FIFO.
// Good bytes are queued for a polling collector. A bad stop bit drops the byte
// and pulses o_ferr. A byte that arrives while the FIFO is full sets the sticky o_ovf.
module uart_rx_fifo #(
    parameter int TICK_DIV0 = 27,
    parameter int TICK_DIV1 = 326,
    parameter int FIFO_AW   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_baud,
    input  logic               i_rx,
    input  logic               i_read,
    output logic               o_ready,
    output logic [7:0]         o_D,
    output logic               o_used,
    output logic [FIFO_AW:0]   o_count,
    output logic               o_ferr,
    output logic               o_ovf
);

    localparam int DIV_MAX = (TICK_DIV0 > TICK_DIV1) ? TICK_DIV0 : TICK_DIV1;
    localparam int TW      = $clog2(DIV_MAX);
    localparam int DEPTH   = 1 << FIFO_AW;

    localparam logic [TW-1:0]      TOP0     = TW'(TICK_DIV0 - 1);
    localparam logic [TW-1:0]      TOP1     = TW'(TICK_DIV1 - 1);
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_WAITHI = 3'd4;

    // ---------------- input synchronizer ----------------
    logic rx_m, rx_s;

    // Two-flop synchronizer; resets to the idle-high line level so no false start bit appears.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= i_rx;
            rx_s <= rx_m;
        end
    end

    // ---------------- 16x tick generator ----------------
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_top;
    logic          tick;

    assign tick = (tick_cnt == tick_top);

    // Free-running divider; the baud selection is reloaded only at a wrap so a period never truncates.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tick_cnt <= '0;
            tick_top <= TOP0;
        end else if (tick) begin
            tick_cnt <= '0;
            tick_top <= i_baud ? TOP1 : TOP0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // ---------------- frame FSM ----------------
    logic [2:0] state;
    logic [3:0] sc;
    logic [2:0] bit_idx;
    logic [7:0] shreg;

    logic [FIFO_AW:0]   count;
    logic [FIFO_AW-1:0] wptr, rptr;
    logic               full, pop, push, stop_tick, stop_good, stop_bad;

    assign stop_tick = tick && (state == S_STOP) && (sc == 4'd15);
    assign stop_good = stop_tick && rx_s;
    assign stop_bad  = stop_tick && !rx_s;
    assign full      = (count == FULL_CNT);
    assign pop       = i_read && (count != '0);
    // A pop in the same edge frees the slot, so a full FIFO still accepts the byte.
    assign push      = stop_good && (!full || pop);

    // Frame sequencing; every transition is qualified by the 16x tick.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= S_IDLE;
            sc      <= 4'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else if (tick) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        sc    <= 4'd0;
                    end
                end
                S_START: begin
                    if (sc == 4'd7) begin
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            sc      <= 4'd0;
                            bit_idx <= 3'd0;
                        end
                    end else begin
                        sc <= sc + 4'd1;
                    end
                end
                S_DATA: begin
                    if (sc == 4'd15) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        sc      <= 4'd0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end else begin
                        sc <= sc + 4'd1;
                    end
                end
                S_STOP: begin
                    if (sc == 4'd15) begin
                        state <= rx_s ? S_IDLE : S_WAITHI;
                    end else begin
                        sc <= sc + 4'd1;
                    end
                end
                S_WAITHI: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Error flags: o_ferr is a single-cycle pulse, o_ovf holds until reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_ferr <= 1'b0;
            o_ovf  <= 1'b0;
        end else begin
            o_ferr <= stop_bad;
            if (stop_good && full && !pop) o_ovf <= 1'b1;
        end
    end

    // ---------------- FIFO ----------------
    logic [7:0] mem [DEPTH];

    // Storage write; the byte is fully shifted in by the time STOP samples.
    // NOTE: the data array has no reset; count gates o_D, so stale contents are never visible.
    always_ff @(posedge i_clk) begin
        if (push) mem[wptr] <= shreg;
    end

    // Pointers and occupancy; a push and pop on the same edge leave count unchanged.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + FIFO_AW'(1);
            if (pop)  rptr <= rptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign o_ready = (count != '0);
    assign o_D     = o_ready ? mem[rptr] : 8'h00;
    assign o_used  = (state != S_IDLE);
    assign o_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed vectors, multi-cycle corner sequences and a
// randomized run checked against a queue-based model of the receiver.
module tb_uart_rx_fifo;

    localparam int DIV0 = 27;
    // TICK_DIV1 is shrunk so the slow-rate path completes in a practical number of cycles.
    localparam int DIV1 = 5;
    localparam int BIT0 = 16 * DIV0;
    localparam int BIT1 = 16 * DIV1;

    logic       i_clk = 1'b0;
    logic       i_rst, i_baud, i_rx, i_read;
    logic       o_ready, o_used, o_ferr, o_ovf;
    logic [7:0] o_D;
    logic [4:0] o_count;

    uart_rx_fifo #(.TICK_DIV0(DIV0), .TICK_DIV1(DIV1), .FIFO_AW(4)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_baud  (i_baud),
        .i_rx    (i_rx),
        .i_read  (i_read),
        .o_ready (o_ready),
        .o_D     (o_D),
        .o_used  (o_used),
        .o_count (o_count),
        .o_ferr  (o_ferr),
        .o_ovf   (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int ferr_cnt = 0;
    always @(posedge i_clk) if (o_ferr) ferr_cnt <= ferr_cnt + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int bitclk  = BIT0;

    logic [7:0] q[$];
    logic       ovf_exp;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         cnt_pre;
        int         reads;
        int         cnt_post;
        logic [7:0] head;
        int         ferr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        n_tests++;
        if (val < lo || val > hi) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        clk_wait(n);
    endtask

    // Start frames on a fixed phase of the tick divider so push timing repeats frame to frame.
    task automatic align();
        while ((cyc % (bitclk / 16)) != 0) @(negedge i_clk);
    endtask

    // Drives one 8N1 frame; leaves the line at the stop-bit level.
    // push_at: first cycle index whose edge changed o_count (-1 if never).
    task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_at,
                              output int push_at, output logic used_hi);
        logic [4:0] cnt0;
        int         b;
        cnt0    = o_count;
        push_at = -1;
        used_hi = 1'b0;
        for (int c = 0; c < 10 * bitclk; c++) begin
            b      = c / bitclk;
            i_rx   = (b == 0) ? 1'b0 : (b <= 8) ? d[b-1] : stop;
            i_read = (c == rd_at);
            @(negedge i_clk);
            if (o_used) used_hi = 1'b1;
            if (push_at < 0 && o_count != cnt0) push_at = c;
        end
        i_read = 1'b0;
    endtask

    task automatic pulse_read();
        i_read = 1'b1;
        @(negedge i_clk);
        i_read = 1'b0;
    endtask

    // Model-checked pop: compare head against the model queue, then read.
    task automatic pop_check(input string name);
        if (q.size() != 0) begin
            check({name, "_head"}, o_D, q[0]);
            void'(q.pop_front());
        end else begin
            check({name, "_empty"}, o_ready, 0);
        end
        pulse_read();
        check({name, "_cnt"}, o_count, q.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[6];
        int         p, p3, fbase, nrd;
        logic       uh;
        logic [7:0] d;
        logic       st;
        int         last_used;
        logic       saw_used;

        vecs[0] = '{8'h5A, 1'b1, 1, 0, 1, 8'h5A, 0};
        vecs[1] = '{8'hC3, 1'b1, 2, 0, 2, 8'h5A, 0};
        vecs[2] = '{8'h3C, 1'b0, 2, 0, 2, 8'h5A, 1};
        vecs[3] = '{8'hFF, 1'b1, 3, 1, 2, 8'hC3, 1};
        vecs[4] = '{8'h00, 1'b1, 3, 2, 1, 8'h00, 1};
        vecs[5] = '{8'h81, 1'b1, 2, 3, 0, 8'h00, 1};

        i_rst = 1'b0; i_baud = 1'b0; i_rx = 1'b1; i_read = 1'b0;
        clk_wait(5);
        check("rst_ready", o_ready, 0);
        check("rst_d",     o_D,     8'h00);
        check("rst_used",  o_used,  0);
        check("rst_count", o_count, 0);
        check("rst_ferr",  o_ferr,  0);
        check("rst_ovf",   o_ovf,   0);
        i_rst = 1'b1;

        // 0xA5 at the fast rate: latency from the start edge to o_ready.
        clk_wait(19);
        bitclk = BIT0;
        send_frame(8'hA5, 1'b1, -1, p, uh);
        idle(bitclk);
        check("a5_used_seen", uh, 1);
        check_range("a5_latency", p, 4070, 4130);
        check("a5_data", o_D, 8'hA5);
        pulse_read();
        check("a5_ready_after_read", o_ready, 0);
        check("a5_count_after_read", o_count, 0);

        // Short low pulse: START must reject it. Detection can lag the edge by up to one tick.
        saw_used = 1'b0; last_used = -1;
        for (int c = 0; c < 300; c++) begin
            i_rx = (c < 100) ? 1'b0 : 1'b1;
            @(negedge i_clk);
            if (o_used) begin saw_used = 1'b1; last_used = c; end
        end
        check("glitch_used_seen", saw_used, 1);
        check_range("glitch_used_drop", last_used, 150, 250);
        check("glitch_no_push", o_count, 0);

        // Switch to the slow rate.
        i_baud = 1'b1;
        bitclk = BIT1;
        idle(100);

        // Table-driven frames with interleaved reads.
        fbase = ferr_cnt;
        foreach (vecs[i]) begin
            align();
            send_frame(vecs[i].data, vecs[i].stop, -1, p, uh);
            idle(bitclk);
            check($sformatf("vec%0d_cnt_pre", i), o_count, vecs[i].cnt_pre);
            for (int r = 0; r < vecs[i].reads; r++) pulse_read();
            check($sformatf("vec%0d_cnt_post", i), o_count, vecs[i].cnt_post);
            check($sformatf("vec%0d_head", i), o_D, vecs[i].head);
            check($sformatf("vec%0d_ferr", i), ferr_cnt - fbase, vecs[i].ferr);
        end

        // Bad stop bit followed by a 20-bit break: one o_ferr, no bytes.
        fbase = ferr_cnt;
        align();
        send_frame(8'h3C, 1'b0, -1, p, uh);
        clk_wait(20 * bitclk);
        check("break_waithi_used", o_used, 1);
        idle(2 * bitclk);
        check("break_used_release", o_used, 0);
        check("break_ferr_once", ferr_cnt - fbase, 1);
        check("break_count", o_count, 0);
        align();
        send_frame(8'h11, 1'b1, -1, p, uh);
        idle(bitclk);
        check("after_break_cnt", o_count, 1);
        check("after_break_data", o_D, 8'h11);
        pulse_read();

        // Seventeen bytes with no reads: sixteen kept, the last one overflows.
        for (int i = 0; i <= 16; i++) begin
            align();
            send_frame(8'(i), 1'b1, -1, p, uh);
            idle(bitclk);
        end
        check("full_count", o_count, 16);
        check("full_ovf", o_ovf, 1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("full_pop%0d", i), o_D, i);
            pulse_read();
        end
        check("drained_ready", o_ready, 0);
        pulse_read();
        check("read_empty_count", o_count, 0);
        check("ovf_sticky", o_ovf, 1);

        // Reset mid-frame with a byte queued.
        align();
        send_frame(8'h77, 1'b1, -1, p, uh);
        idle(bitclk);
        i_rx = 1'b0;
        clk_wait(3 * bitclk);
        i_rst = 1'b0;
        clk_wait(3);
        check("midrst_count", o_count, 0);
        check("midrst_used", o_used, 0);
        check("midrst_ovf", o_ovf, 0);
        i_rx = 1'b1;
        clk_wait(2);
        i_rst = 1'b1;
        idle(100);
        check("midrst_no_frame", o_used, 0);

        // Simultaneous push and pop: pop lands on the 4th byte's push edge.
        align(); send_frame(8'h21, 1'b1, -1, p, uh); idle(bitclk);
        align(); send_frame(8'h22, 1'b1, -1, p, uh); idle(bitclk);
        align(); send_frame(8'h23, 1'b1, -1, p3, uh); idle(bitclk);
        check("sim_pre_cnt", o_count, 3);
        align(); send_frame(8'h24, 1'b1, p3, p, uh); idle(bitclk);
        check("sim_push_found", (p3 >= 0), 1);
        check("sim_cnt_never_moved", p, 32'hFFFF_FFFF);
        check("sim_cnt_post", o_count, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sim_order%0d", i), o_D, 8'h22 + 8'(i));
            pulse_read();
        end
        check("sim_empty", o_ready, 0);

        // Randomized frames with a queue model of the FIFO.
        q.delete();
        ovf_exp = 1'b0;
        fbase   = ferr_cnt;
        p3      = 0;
        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 9) != 0);
            align();
            send_frame(d, st, -1, p, uh);
            idle(bitclk);
            if (!st)                p3++;
            else if (q.size() < 16) q.push_back(d);
            else                    ovf_exp = 1'b1;
            check($sformatf("rnd%0d_cnt", n), o_count, q.size());
            check($sformatf("rnd%0d_ovf", n), o_ovf, ovf_exp);
            nrd = $urandom_range(0, 2);
            for (int r = 0; r < nrd; r++) pop_check($sformatf("rnd%0d_rd%0d", n, r));
        end
        check("rnd_ferr_total", ferr_cnt - fbase, p3);
        while (q.size() != 0) pop_check("rnd_drain");
        check("rnd_final_ready", o_ready, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
